// File: rtl/sap1_seq_ctrl_if.sv
// Load-stream and front-panel memory bus between the sap1 sequencer and its surroundings.
// The sequencer side uses the master modport; the feeder/core side uses slave.
interface sap1_seq_ctrl_if #(
  parameter int unsigned ADR_W  = 4,
  parameter int unsigned DATA_W = 8
);
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic              fp_prog;
  logic              fp_write;
  logic [ADR_W-1:0]  fp_adr;
  logic [DATA_W-1:0] fp_data;
  logic              fp_clear;

  modport master (
    input  ld_valid, ld_data,
    output ld_ready, fp_prog, fp_write, fp_adr, fp_data, fp_clear
  );

  modport slave (
    output ld_valid, ld_data,
    input  ld_ready, fp_prog, fp_write, fp_adr, fp_data, fp_clear
  );
endinterface

// File: rtl/sap1_seq_ctrl.sv
// Run/load sequencer for the sap1 core: streams a program into memory, clears the core,
// then issues clken/clken_oop either free-running or one T-state per step pulse.
module sap1_seq_ctrl #(
  parameter int unsigned ADR_W      = 4,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned CLR_CYCLES = 4
) (
  input  logic            sysclk,
  input  logic            reset_n,
  input  logic            ld_start,
  input  logic            restart,
  input  logic            run_mode,
  input  logic            step,
  input  logic            halt,
  sap1_seq_ctrl_if.master bus,
  output logic            clken,
  output logic            clken_oop,
  output logic            busy,
  output logic [2:0]      state_o
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLoad   = 3'd1,
    StWrite  = 3'd2,
    StClear  = 3'd3,
    StRun    = 3'd4,
    StHalted = 3'd5
  } state_e;

  localparam int unsigned DivW = $clog2(CLK_DIV);
  localparam int unsigned CntW = $clog2(CLR_CYCLES);

  localparam logic [DivW-1:0]  DivLast = DivW'(CLK_DIV - 1);
  localparam logic [DivW-1:0]  DivHalf = DivW'(CLK_DIV / 2);
  localparam logic [CntW-1:0]  ClrLast = CntW'(CLR_CYCLES - 1);
  localparam logic [CntW-1:0]  ClrEn   = CntW'(CLR_CYCLES - 2);
  localparam logic [ADR_W-1:0] AdrLast = {ADR_W{1'b1}};

  state_e            state_q, state_d;
  logic [ADR_W-1:0]  adr_q, adr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DivW-1:0]   div_q, div_d, div_inc;
  logic              pend_q, pend_d;
  logic              halt_seen_q, halt_seen_d;
  logic              ld_ready_q, ld_ready_d;
  logic              prog_q, prog_d;
  logic              write_q, write_d;
  logic              clear_q, clear_d;
  logic              clken_q, clken_d;
  logic              oop_q, oop_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d     = state_q;
    adr_d       = adr_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    div_inc     = div_q + DivW'(1);
    pend_d      = pend_q;
    halt_seen_d = halt_seen_q;
    clken_d     = 1'b0;
    oop_d       = 1'b0;

    unique case (state_q)
      StIdle, StHalted: begin
        if (ld_start) begin
          state_d = StLoad;
          adr_d   = '0;
        end else if (restart) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      StLoad: begin
        // ld_ready is high throughout LOAD, so valid alone completes the handshake
        if (bus.ld_valid) begin
          data_d  = bus.ld_data;
          state_d = StWrite;
        end
      end
      StWrite: begin
        adr_d = adr_q + ADR_W'(1);
        if (adr_q == AdrLast) begin
          state_d = StClear;
          cnt_d   = '0;
        end else begin
          state_d = StLoad;
        end
      end
      StClear: begin
        adr_d       = '0;
        div_d       = '0;
        pend_d      = 1'b0;
        halt_seen_d = 1'b0;
        if (cnt_q == ClrLast) begin
          state_d = StRun;
          if (run_mode) begin
            clken_d = 1'b1;
            pend_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRun: begin
        halt_seen_d = halt_seen_q | halt;
        if (ld_start) begin
          state_d = StLoad;
          adr_d   = '0;
          div_d   = '0;
          pend_d  = 1'b0;
        end else if (pend_q) begin
          // A T-state in flight finishes identically in either mode
          div_d = div_inc;
          if (div_inc == DivHalf) begin
            oop_d  = 1'b1;
            pend_d = 1'b0;
          end
        end else if (halt_seen_q || halt) begin
          state_d = StHalted;
          div_d   = '0;
        end else if (run_mode) begin
          // div_q==0 outside a T-state means the divider was idle: start at once
          if (div_q == DivLast || div_q == '0) begin
            div_d   = '0;
            clken_d = 1'b1;
            pend_d  = 1'b1;
          end else begin
            div_d = div_inc;
          end
        end else begin
          div_d = '0;
          if (step) begin
            clken_d = 1'b1;
            pend_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_d == StClear) begin
      clken_d = (cnt_d == ClrEn);
      oop_d   = (cnt_d == ClrLast);
    end
    if (state_d == StWrite) begin
      oop_d = 1'b1;
    end

    ld_ready_d = (state_d == StLoad);
    prog_d     = (state_d == StLoad) || (state_d == StWrite);
    write_d    = (state_d == StWrite);
    clear_d    = (state_d == StClear);
    busy_d     = (state_d == StLoad) || (state_d == StWrite) || (state_d == StClear);
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      adr_q       <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      div_q       <= '0;
      pend_q      <= 1'b0;
      halt_seen_q <= 1'b0;
      ld_ready_q  <= 1'b0;
      prog_q      <= 1'b0;
      write_q     <= 1'b0;
      clear_q     <= 1'b0;
      clken_q     <= 1'b0;
      oop_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      adr_q       <= adr_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      pend_q      <= pend_d;
      halt_seen_q <= halt_seen_d;
      ld_ready_q  <= ld_ready_d;
      prog_q      <= prog_d;
      write_q     <= write_d;
      clear_q     <= clear_d;
      clken_q     <= clken_d;
      oop_q       <= oop_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.ld_ready = ld_ready_q;
  assign bus.fp_prog  = prog_q;
  assign bus.fp_write = write_q;
  assign bus.fp_adr   = adr_q;
  assign bus.fp_data  = data_q;
  assign bus.fp_clear = clear_q;
  assign clken        = clken_q;
  assign clken_oop    = oop_q;
  assign busy         = busy_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_sap1_seq_ctrl.sv
// Self-checking bench for sap1_seq_ctrl: program loads with random gaps against a memory
// model, clear/run enable timing, timestamp-based step model, halt, abort and reset.
module tb_sap1_seq_ctrl;
  localparam int ADR_W   = 4;
  localparam int DATA_W  = 8;
  localparam int CLK_DIV = 4;
  localparam int CLR     = 4;
  localparam int HALF    = CLK_DIV / 2;
  localparam int DEPTH   = 1 << ADR_W;

  logic       sysclk;
  logic       reset_n;
  logic       ld_start, restart, run_mode, step, halt;
  logic       clken, clken_oop, busy;
  logic [2:0] state_o;

  int checks;
  int errors;

  logic [DATA_W-1:0] prog    [DEPTH];
  logic [DATA_W-1:0] mem     [DEPTH];
  bit                written [DEPTH];

  sap1_seq_ctrl_if #(.ADR_W(ADR_W), .DATA_W(DATA_W)) bus ();

  sap1_seq_ctrl #(
    .ADR_W     (ADR_W),
    .DATA_W    (DATA_W),
    .CLK_DIV   (CLK_DIV),
    .CLR_CYCLES(CLR)
  ) dut (
    .sysclk   (sysclk),
    .reset_n  (reset_n),
    .ld_start (ld_start),
    .restart  (restart),
    .run_mode (run_mode),
    .step     (step),
    .halt     (halt),
    .bus      (bus),
    .clken    (clken),
    .clken_oop(clken_oop),
    .busy     (busy),
    .state_o  (state_o)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic new_prog(input bit fixed_head);
    for (int i = 0; i < DEPTH; i++) begin
      prog[i]    = DATA_W'($urandom);
      written[i] = 1'b0;
    end
    if (fixed_head) begin
      prog[0] = 8'h0E; prog[1] = 8'h1F; prog[2] = 8'hE0; prog[3] = 8'hF0;
    end
  endtask

  // Upstream feeder plus write monitor; starts on the first cycle LOAD is visible.
  task automatic load_prog(input int max_gap, input int nbytes, output int last_cyc);
    int idx = 0;
    int gap = 0;
    int wr  = 0;
    int cyc = 1;
    bit take = 1'b0;
    last_cyc = 0;
    while (wr < nbytes && cyc < 400) begin
      if (bus.fp_prog) chk("ready_not_write", 32'(bus.ld_ready), 32'(!bus.fp_write));
      if (bus.fp_write) begin
        chk("wr_adr", 32'(bus.fp_adr), wr);
        chk("wr_data", 32'(bus.fp_data), 32'(prog[wr % DEPTH]));
        mem[bus.fp_adr]     = bus.fp_data;
        written[bus.fp_adr] = 1'b1;
        wr++;
        last_cyc = cyc;
      end
      if (wr < nbytes) begin
        if (take) begin
          idx++;
          bus.ld_valid = 1'b0;
          gap = $urandom_range(max_gap, 0);
        end
        if (!bus.ld_valid && idx < DEPTH) begin
          if (gap == 0) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = prog[idx];
          end else begin
            gap--;
          end
        end
        take = bus.ld_valid && bus.ld_ready;
        @(negedge sysclk);
        cyc++;
      end
    end
    chk("load_bytes_written", wr, nbytes);
  endtask

  task automatic check_mem();
    for (int i = 0; i < DEPTH; i++) begin
      chk("mem_written", 32'(written[i]), 1);
      chk("mem_data", 32'(mem[i]), 32'(prog[i]));
    end
  endtask

  // Starts on the first CLEAR cycle; continues 12 cycles into RUN.
  task automatic check_clear_run(input bit mode);
    for (int i = 0; i < CLR; i++) begin
      chk("clr_clear", 32'(bus.fp_clear), 1);
      chk("clr_prog", 32'(bus.fp_prog), 0);
      chk("clr_busy", 32'(busy), 1);
      chk("clr_clken", 32'(clken), 32'(i == CLR - 2));
      chk("clr_oop", 32'(clken_oop), 32'(i == CLR - 1));
      @(negedge sysclk);
    end
    for (int t = 0; t < 12; t++) begin
      chk("run_state", 32'(state_o), 4);
      chk("run_busy", 32'(busy), 0);
      chk("run_clear", 32'(bus.fp_clear), 0);
      chk("run_clken", 32'(clken), 32'(mode && (t % CLK_DIV == 0)));
      chk("run_oop", 32'(clken_oop), 32'(mode && (t % CLK_DIV == HALF)));
      @(negedge sysclk);
    end
  endtask

  // Step-mode model: a step driven in cycle c is taken iff c is not before the
  // oop cycle of the last taken step; it yields clken at c+1 and oop at c+1+HALF.
  task automatic step_run(input logic [63:0] pat, input int ncyc, output int seen);
    bit ec [80];
    bit eo [80];
    int busy_until = 0;
    int expn = 0;
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      ec[i] = 1'b0;
      eo[i] = 1'b0;
    end
    for (int c = 0; c < ncyc; c++) begin
      chk("step_clken", 32'(clken), 32'(ec[c]));
      chk("step_oop", 32'(clken_oop), 32'(eo[c]));
      if (clken) seen++;
      step = 1'b0;
      if (pat[c] && c < ncyc - HALF - 2) begin
        step = 1'b1;
        if (c >= busy_until) begin
          ec[c + 1]        = 1'b1;
          eo[c + 1 + HALF] = 1'b1;
          busy_until       = c + 1 + HALF;
          expn++;
        end
      end
      @(negedge sysclk);
    end
    step = 1'b0;
    chk("step_pair_count", seen, expn);
  endtask

  initial begin
    int lc;
    int seen;
    bit found;
    checks       = 0;
    errors       = 0;
    reset_n      = 1'b0;
    ld_start     = 1'b0;
    restart      = 1'b0;
    run_mode     = 1'b1;
    step         = 1'b0;
    halt         = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_data  = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;

    repeat (3) @(negedge sysclk);
    chk("reset_outputs", {bus.ld_ready, bus.fp_prog, bus.fp_write, bus.fp_adr, bus.fp_data,
                          bus.fp_clear, clken, clken_oop, busy, state_o}, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge sysclk);
    chk("idle_state", 32'(state_o), 0);
    chk("idle_enables", 32'({clken, clken_oop}), 0);

    // Back-to-back load with valid held: one byte every 2 cycles
    new_prog(1'b1);
    ld_start = 1'b1;
    @(negedge sysclk);
    ld_start = 1'b0;
    load_prog(0, DEPTH, lc);
    chk("load_throughput", lc, 2 * DEPTH);
    bus.ld_valid = 1'b0;
    check_mem();
    @(negedge sysclk);
    check_clear_run(1'b1);

    // Halt while a T-state is pending
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (clken) begin
        found = 1'b1;
        break;
      end
      @(negedge sysclk);
    end
    chk("halt_wait_clken", 32'(found), 1);
    halt = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge sysclk);
      chk("halt_clken", 32'(clken), 0);
      chk("halt_oop", 32'(clken_oop), 32'(k == HALF));
      if (k > HALF) chk("halt_state", 32'(state_o), 5);
    end
    halt     = 1'b0;
    run_mode = 1'b0;
    restart  = 1'b1;
    @(negedge sysclk);
    restart = 1'b0;
    check_clear_run(1'b0);

    // Directed steps at cycles 0,1,5: the second is dropped
    step_run(64'h23, 16, seen);
    chk("step_directed_pairs", seen, 2);
    for (int r = 0; r < 3; r++) begin
      step_run({$urandom, $urandom}, 64, seen);
    end

    // Abort a free run with ld_start, reload with random gaps
    run_mode = 1'b1;
    repeat ($urandom_range(10, 3)) @(negedge sysclk);
    ld_start = 1'b1;
    @(negedge sysclk);
    ld_start = 1'b0;
    chk("abort_state", 32'(state_o), 1);
    chk("abort_ready", 32'(bus.ld_ready), 1);
    chk("abort_adr", 32'(bus.fp_adr), 0);
    chk("abort_enables", 32'({clken, clken_oop}), 0);
    new_prog(1'b0);
    load_prog(5, DEPTH, lc);
    bus.ld_valid = 1'b0;
    check_mem();
    @(negedge sysclk);
    check_clear_run(1'b1);

    // Reset after the 8th byte, then reload from address 0
    ld_start = 1'b1;
    @(negedge sysclk);
    ld_start = 1'b0;
    new_prog(1'b0);
    load_prog(3, 8, lc);
    reset_n = 1'b0;
    #1;
    chk("midload_reset_outputs", {bus.ld_ready, bus.fp_prog, bus.fp_write, bus.fp_adr,
                                  bus.fp_data, bus.fp_clear, clken, clken_oop, busy,
                                  state_o}, 0);
    bus.ld_valid = 1'b0;
    @(negedge sysclk);
    reset_n = 1'b1;
    @(negedge sysclk);
    chk("post_reset_idle", 32'(state_o), 0);
    new_prog(1'b0);
    ld_start = 1'b1;
    restart  = 1'b1;
    @(negedge sysclk);
    ld_start = 1'b0;
    restart  = 1'b0;
    chk("start_beats_restart", 32'(state_o), 1);
    load_prog(2, DEPTH, lc);
    bus.ld_valid = 1'b0;
    check_mem();
    @(negedge sysclk);
    check_clear_run(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
